// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal TX FIFO.
//   Frames go out LSB first: start bit, DATA_BITS data bits, an optional parity
//   bit, then STOP_BITS stop bits. Queued words go out back-to-back with no idle
//   gap between frames. The line idles high.
//
// Ports:
//   i_clk         system clock
//   i_rstn        asynchronous active-low reset
//   i_wr_valid    write request
//   i_wr_data     word to transmit (DATA_BITS wide)
//   o_wr_ready    FIFO not full; a write is taken when i_wr_valid && o_wr_ready
//   o_fifo_count  entries queued, excluding the word being shifted
//   o_uarttx      serial line, registered
//   o_txactive    high while any frame bit is on the line
//   o_txdone      one-cycle pulse at the end of each frame
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rstn,
  input  logic                                i_wr_valid,
  input  logic [DATA_BITS-1:0]                i_wr_data,
  output logic                                o_wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_count,
  output logic                                o_uarttx,
  output logic                                o_txactive,
  output logic                                o_txdone
);

  if (CLKS_PER_BIT < 2) begin : g_err_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_fd
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Parity bit sent after the data: odd -> XNOR reduction, even -> XOR reduction.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 uarttx_q, uarttx_d;
  logic                 txactive_q, txactive_d;
  logic                 txdone_q, txdone_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]    count_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;

  logic                 push, pop, bit_end;

  assign o_wr_ready   = (count_q != FIFO_FULL);
  assign o_fifo_count = count_q;
  assign o_uarttx     = uarttx_q;
  assign o_txactive   = txactive_q;
  assign o_txdone     = txdone_q;

  assign push    = i_wr_valid && o_wr_ready;
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    uarttx_d   = uarttx_q;
    txactive_d = txactive_q;
    txdone_d   = 1'b0;
    pop        = 1'b0;
    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        uarttx_d = 1'b1;
        if (count_q != '0) begin
          pop        = 1'b1;
          uarttx_d   = 1'b0;
          txactive_d = 1'b1;
          clk_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          uarttx_d  = sh_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              uarttx_d = par_q;
              state_d  = PAR;
            end else begin
              uarttx_d = 1'b1;
              state_d  = STOP;
            end
          end else begin
            // sh_q shifts on this same edge, so the next bit is sh_q[1] now.
            bit_idx_d = bit_idx_q + 1'b1;
            uarttx_d  = sh_q[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          uarttx_d  = 1'b1;
          bit_idx_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            txdone_d  = 1'b1;
            bit_idx_d = '0;
            if (count_q != '0) begin
              // Next frame starts immediately; the line goes low on this edge.
              pop      = 1'b1;
              uarttx_d = 1'b0;
              state_d  = START;
            end else begin
              uarttx_d   = 1'b1;
              txactive_d = 1'b0;
              state_d    = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        uarttx_d   = 1'b1;
        txactive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      uarttx_q   <= 1'b1;
      txactive_q <= 1'b0;
      txdone_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      uarttx_q   <= uarttx_d;
      txactive_q <= txactive_d;
      txdone_q   <= txdone_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage and shift register hold data only; their contents are don't-care
  // until written, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_wr_data;
    if (pop) begin
      sh_q  <= mem[rd_ptr_q];
      par_q <= parity_of(mem[rd_ptr_q]);
    end else if (state_q == DATA && bit_end) begin
      sh_q  <= sh_q >> 1;
    end
  end

endmodule
